// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, oversampling constant and baud divisor math.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int sys_clk, input int baud);
    return (sys_clk + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 16x oversample tick generator shared by RX and TX.
// Latency: tick_o is a one-cycle pulse every DIV clocks; sync_i restarts the period.
// Backpressure: none, free-running.
// Ports: clk_i/rst_i clock and async active-high reset, sync_i restart counter,
//        tick_o one-cycle oversample tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int SYS_CLK   = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic tick_o
);

  localparam int DIV = calc_div(SYS_CLK, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (sync_i || (cnt_q == LAST)) cnt_d = '0;
    else                           cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart.sv
// uart: full-duplex 8N1-style transceiver, 16x oversampled RX and TX on one baud tick.
// Latency: rx_done_tick_o one clk after mid-stop sampling; tx_o goes low one clk after tx_start_i.
// Backpressure: none; tx_start_i is dropped while TX is busy (including its done cycle).
// Ports: clk_i/rst_i clock and async active-high reset; rx_i serial in (idle high);
//        rx_done_tick_o/rx_data_o received byte; tx_start_i/tx_data_i send request;
//        tx_o serial out (idle high); tx_done_tick_o end of last stop bit.
// Optional: define UART_FRAME_ERR_EN to add frame_err_o (stop-bit level check).
module uart
  import uart_pkg::*;
#(
  parameter int SYS_CLK   = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BIT  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic                 rx_done_tick_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_o,
  output logic                 tx_done_tick_o
`ifdef UART_FRAME_ERR_EN
  ,
  output logic                 frame_err_o
`endif
);

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] MID_START = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] STOP_LAST = 5'(OVERSAMPLE * STOP_BIT - 1);
  localparam logic [2:0] N_LAST    = 3'(DATA_BITS - 1);

  logic tick, baud_sync;

  // TX restarts the shared tick so its start bit is a full 16 ticks long.
  // RX tolerates the phase jump: it only counts ticks relative to its own start edge.
  uart_baud_gen #(.SYS_CLK(SYS_CLK), .BAUD_RATE(BAUD_RATE)) u_baud_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sync_i (baud_sync),
    .tick_o (tick)
  );

  // ---------------- RX ----------------
  logic                 rx_meta_q, rx_sync_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [4:0]           rx_s_q, rx_s_d;
  logic [2:0]           rx_n_q, rx_n_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
`ifdef UART_FRAME_ERR_EN
  logic                 rx_bad_q, rx_bad_d, frame_err_q, frame_err_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      IDLE:    if (!rx_sync_q) rx_state_d = START;
      START:   if (tick && rx_s_q == MID_START) rx_state_d = rx_sync_q ? IDLE : DATA;
      DATA:    if (tick && rx_s_q == BIT_LAST && rx_n_q == N_LAST) rx_state_d = STOP;
      STOP:    if (tick && rx_s_q == STOP_LAST) rx_state_d = IDLE;
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
`ifdef UART_FRAME_ERR_EN
    rx_bad_d    = rx_bad_q;
    frame_err_d = 1'b0;
`endif
    case (rx_state_q)
      IDLE: if (!rx_sync_q) rx_s_d = '0;
      START: if (tick) begin
        if (rx_s_q == MID_START) begin
          rx_s_d = '0;
          rx_n_d = '0;
        end else begin
          rx_s_d = rx_s_q + 5'd1;
        end
      end
      DATA: if (tick) begin
        if (rx_s_q == BIT_LAST) begin
          rx_s_d     = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_n_d     = rx_n_q + 3'd1;
        end else begin
          rx_s_d = rx_s_q + 5'd1;
        end
      end
      STOP: if (tick) begin
`ifdef UART_FRAME_ERR_EN
        // Mid point of the first stop bit.
        if (rx_s_q == BIT_LAST) rx_bad_d = !rx_sync_q;
`endif
        if (rx_s_q == STOP_LAST) begin
`ifdef UART_FRAME_ERR_EN
          if (rx_bad_d) begin
            frame_err_d = 1'b1;
          end else begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
`else
          rx_data_d = rx_shift_q;
          rx_done_d = 1'b1;
`endif
        end else begin
          rx_s_d = rx_s_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

`ifdef UART_FRAME_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_bad_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_bad_q    <= rx_bad_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err_o = frame_err_q;
`endif

  assign rx_done_tick_o = rx_done_q;
  assign rx_data_o      = rx_data_q;

  // ---------------- TX ----------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [4:0]           tx_s_q, tx_s_d;
  logic [2:0]           tx_n_q, tx_n_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      IDLE:    if (tx_start_i) tx_state_d = START;
      START:   if (tick && tx_s_q == BIT_LAST) tx_state_d = DATA;
      DATA:    if (tick && tx_s_q == BIT_LAST && tx_n_q == N_LAST) tx_state_d = STOP;
      STOP:    if (tick && tx_s_q == STOP_LAST) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_shift_d = tx_shift_q;
    baud_sync  = 1'b0;
    case (tx_state_q)
      IDLE: if (tx_start_i) begin
        tx_shift_d = tx_data_i;
        tx_s_d     = '0;
        baud_sync  = 1'b1;
      end
      START: if (tick) begin
        if (tx_s_q == BIT_LAST) begin
          tx_s_d = '0;
          tx_n_d = '0;
        end else begin
          tx_s_d = tx_s_q + 5'd1;
        end
      end
      DATA: if (tick) begin
        if (tx_s_q == BIT_LAST) begin
          tx_s_d     = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_n_d     = tx_n_q + 3'd1;
        end else begin
          tx_s_d = tx_s_q + 5'd1;
        end
      end
      STOP: if (tick) tx_s_d = tx_s_q + 5'd1;
      default: ;
    endcase
    // Line level is decoded from the state being entered, so tx_o changes
    // on the same edge as the state and stays a clean flop output.
    case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Done fires in the last STOP cycle; TX is IDLE on the next clock,
  // so a start arriving in the done cycle is naturally ignored.
  always_comb begin
    tx_o           = tx_q;
    tx_done_tick_o = (tx_state_q == STOP) && tick && (tx_s_q == STOP_LAST);
  end

endmodule

// File: tb/tb_uart.sv
module tb_uart;
  localparam int BIT_CLK = 434;      // 8680 ns bit at a 20 ns clock
  localparam int TX_BIT  = 16 * 27;  // transmitter bit width in clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tx_start_r = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] tx_data_r = 8'h00;
  logic       tx_start, rx_done, tx_done, tx_line;
  logic [7:0] tx_data, rx_data;
`ifdef UART_FRAME_ERR_EN
  logic       ferr;
`endif

  assign tx_start = loop_en ? rx_done : tx_start_r;
  assign tx_data  = loop_en ? rx_data : tx_data_r;

  uart dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_i           (rx),
    .rx_done_tick_o (rx_done),
    .rx_data_o      (rx_data),
    .tx_start_i     (tx_start),
    .tx_data_i      (tx_data),
    .tx_o           (tx_line),
    .tx_done_tick_o (tx_done)
`ifdef UART_FRAME_ERR_EN
    ,
    .frame_err_o    (ferr)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0, rx_cnt = 0, tx_cnt = 0, ferr_cnt = 0, rx_done_cyc = 0;
  int n_cmp = 0, n_err = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_done) begin
      rx_cnt      <= rx_cnt + 1;
      rx_done_cyc <= cyc;
    end
    if (tx_done) tx_cnt <= tx_cnt + 1;
`ifdef UART_FRAME_ERR_EN
    if (ferr) ferr_cnt <= ferr_cnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on rx: start, 8 data bits LSB first, one stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
  endtask

  // Wait for a tx frame, check low-run of start (+ leading zero bits), bits, stop.
  task automatic decode_frame(input logic [7:0] exp, input string tag);
    int t, first_hi, k;
    logic [8:0] got;
    t = 0;
    while (tx_line !== 1'b0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " start seen"}, 32'(t < 20000), 32'd1);
    if (t >= 20000) return;
    k = 1;
    for (int i = 0; i < 8; i++) begin
      if (exp[i] != 1'b0) break;
      k++;
    end
    first_hi = -1;
    got = '0;
    // j counts negedges since the falling edge was seen (0.5 clk into start bit).
    for (int j = 0; j < 9 * TX_BIT + TX_BIT / 2 + 6; j++) begin
      if (first_hi < 0 && tx_line === 1'b1) first_hi = j;
      if (j >= TX_BIT + TX_BIT / 2 && ((j - TX_BIT - TX_BIT / 2) % TX_BIT) == 0)
        got[(j - TX_BIT - TX_BIT / 2) / TX_BIT] = tx_line;
      @(negedge clk);
    end
    chk({tag, " low-run width"}, 32'(first_hi >= k * TX_BIT - 1 && first_hi <= k * TX_BIT + 1), 32'd1);
    chk({tag, " data"}, 32'(got[7:0]), 32'(exp));
    chk({tag, " stop high"}, 32'(got[8]), 32'd1);
  endtask

  initial begin
    int base_rx, base_tx, base_fe, fs, lows;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst tx_o", 32'(tx_line), 32'd1);
    chk("rst rx_done", 32'(rx_done), 32'd0);
    chk("rst tx_done", 32'(tx_done), 32'd0);
    chk("rst rx_data", 32'(rx_data), 32'd0);
`ifdef UART_FRAME_ERR_EN
    chk("rst frame_err", 32'(ferr), 32'd0);
`endif
    rst = 1'b0;
    repeat (10000) @(negedge clk);
    chk("idle rx ticks", 32'(rx_cnt), 32'd0);
    chk("idle tx ticks", 32'(tx_cnt), 32'd0);

    // Single RX byte
    base_rx = rx_cnt;
    fs = cyc;
    send_byte(8'hA5, 1'b1);
    repeat (BIT_CLK / 2) @(negedge clk);
    chk("A5 count", 32'(rx_cnt - base_rx), 32'd1);
    chk("A5 data", 32'(rx_data), 32'hA5);
    // The 27-clock tick quantisation lets the sample point drift by up
    // to a tick, so accept a done anywhere from stop-bit start to 1.5 bits after.
    chk("A5 latency", 32'(rx_done_cyc - fs >= 9 * BIT_CLK && rx_done_cyc - fs <= BIT_CLK * 21 / 2), 32'd1);

    // Loopback echo, three frames back to back
    loop_en = 1'b1;
    base_rx = rx_cnt;
    base_tx = tx_cnt;
    fork
      begin
        send_byte(8'h55, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1);
      end
      begin
        decode_frame(8'h55, "lb 55");
        decode_frame(8'h03, "lb 03");
        decode_frame(8'hFF, "lb FF");
      end
    join
    repeat (BIT_CLK) @(negedge clk);
    loop_en = 1'b0;
    chk("lb rx count", 32'(rx_cnt - base_rx), 32'd3);
    chk("lb tx count", 32'(tx_cnt - base_tx), 32'd3);

    // Glitch shorter than half a bit, then a real byte
    base_rx = rx_cnt;
    rx = 1'b0;
    repeat (2 * 27) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("glitch no rx", 32'(rx_cnt - base_rx), 32'd0);
    send_byte(8'h3C, 1'b1);
    repeat (BIT_CLK / 2) @(negedge clk);
    chk("3C count", 32'(rx_cnt - base_rx), 32'd1);
    chk("3C data", 32'(rx_data), 32'h3C);

    // TX busy: second start mid-frame is dropped
    base_tx = tx_cnt;
    fork
      begin
        tx_data_r = 8'h12;
        tx_start_r = 1'b1;
        @(negedge clk);
        tx_start_r = 1'b0;
        repeat (5 * TX_BIT) @(negedge clk);
        tx_data_r = 8'h34;
        tx_start_r = 1'b1;
        @(negedge clk);
        tx_start_r = 1'b0;
      end
      decode_frame(8'h12, "busy 12");
    join
    lows = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx_line !== 1'b1) lows++;
    end
    chk("busy no 2nd frame", 32'(lows), 32'd0);
    chk("busy tx count", 32'(tx_cnt - base_tx), 32'd1);

    // Stop bit driven low
    base_rx = rx_cnt;
    base_fe = ferr_cnt;
    send_byte(8'h7E, 1'b0);
    repeat (BIT_CLK / 2) @(negedge clk);
`ifdef UART_FRAME_ERR_EN
    chk("ferr pulse", 32'(ferr_cnt - base_fe), 32'd1);
    chk("ferr no rx_done", 32'(rx_cnt - base_rx), 32'd0);
    chk("ferr data kept", 32'(rx_data), 32'h3C);
`else
    chk("bad stop ignored fe", 32'(ferr_cnt - base_fe), 32'd0);
    chk("bad stop count", 32'(rx_cnt - base_rx), 32'd1);
    chk("bad stop data", 32'(rx_data), 32'h7E);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
